// File: rtl/hnf_biq_ctl_pkg.sv
// Shared definitions for the HN-F back-invalidation queue sequencer.
package hnf_biq_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_POP   = 2'd3
  } biq_state_e;

  localparam int unsigned BIQ_TIMEOUT_DEF = 1023;

endpackage

// File: rtl/hnf_biq_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module hnf_biq_rr_arb #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search upward from the pointer with wrap-around; first valid requester wins.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_d      = PTR_W'((32'(idx) + 32'd1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hnf_biq_ctl.sv
// HN-F BIQ sequencer: arbitrates eviction pushes and drains the head via snoop/wait/pop.
module hnf_biq_ctl
  import hnf_biq_ctl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 44,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = BIQ_TIMEOUT_DEF,
  parameter int unsigned TO_CNT_WIDTH   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          biq_push,
  output logic [ADDR_WIDTH-1:0]         biq_addr_in,
  output logic                          biq_pop,
  input  logic [ADDR_WIDTH-1:0]         biq_addr_out,
  input  logic                          biq_full,
  input  logic                          biq_empty,
  output logic                          snp_valid,
  input  logic                          snp_ready,
  output logic [ADDR_WIDTH-1:0]         snp_addr,
  input  logic                          snp_done,
  output logic                          ctl_busy,
  output logic                          err_timeout,
  output logic                          err_unexp_done
);

  biq_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [TO_CNT_WIDTH-1:0] wd_q, wd_d, wd_inc;
  logic                    err_to_q, err_to_d;
  logic                    err_ud_q, err_ud_d;

  hnf_biq_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (!biq_full),
    .grant (req_ready)
  );

  assign biq_push = |(req_valid & req_ready);

  always_comb begin
    biq_addr_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) biq_addr_in = biq_addr_in | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign wd_inc = wd_q + TO_CNT_WIDTH'(1);

  // Drain sequencing; a completion outside WAIT only raises the sticky flag.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    err_to_d = err_to_q;
    err_ud_d = err_ud_q | (snp_done && (state_q != ST_WAIT));
    case (state_q)
      ST_IDLE: begin
        if (!biq_empty) begin
          addr_d  = biq_addr_out;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (snp_ready) begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (snp_done) begin
          state_d = ST_POP;
        end else begin
          wd_d = wd_inc;
          if ((TIMEOUT_CYCLES != 0) && (wd_inc == TO_CNT_WIDTH'(TIMEOUT_CYCLES))) begin
            err_to_d = 1'b1;
            state_d  = ST_POP;
          end
        end
      end
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wd_q     <= '0;
      err_to_q <= 1'b0;
      err_ud_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      err_to_q <= err_to_d;
      err_ud_q <= err_ud_d;
    end
  end

  assign snp_valid      = (state_q == ST_ISSUE);
  assign biq_pop        = (state_q == ST_POP);
  assign ctl_busy       = (state_q != ST_IDLE);
  assign snp_addr       = addr_q;
  assign err_timeout    = err_to_q;
  assign err_unexp_done = err_ud_q;

endmodule

// File: tb/tb_hnf_biq_ctl.sv
// Directed vector bench for hnf_biq_ctl with a short watchdog (8 cycles).
module tb_hnf_biq_ctl;

  localparam int unsigned AW = 44;
  localparam int unsigned NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]  req_ready;
  logic           biq_push;
  logic [AW-1:0]  biq_addr_in;
  logic           biq_pop;
  logic [AW-1:0]  biq_addr_out;
  logic           biq_full;
  logic           biq_empty;
  logic           snp_valid;
  logic           snp_ready;
  logic [AW-1:0]  snp_addr;
  logic           snp_done;
  logic           ctl_busy;
  logic           err_timeout;
  logic           err_unexp_done;

  hnf_biq_ctl #(
    .ADDR_WIDTH     (AW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (8),
    .TO_CNT_WIDTH   (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .biq_push       (biq_push),
    .biq_addr_in    (biq_addr_in),
    .biq_pop        (biq_pop),
    .biq_addr_out   (biq_addr_out),
    .biq_full       (biq_full),
    .biq_empty      (biq_empty),
    .snp_valid      (snp_valid),
    .snp_ready      (snp_ready),
    .snp_addr       (snp_addr),
    .snp_done       (snp_done),
    .ctl_busy       (ctl_busy),
    .err_timeout    (err_timeout),
    .err_unexp_done (err_unexp_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] a0, a1;
    logic        full, empty;
    logic [15:0] head;
    logic        srdy, sdone;
    logic [1:0]  e_rdy;
    logic        e_push;
    logic [15:0] e_ain;
    logic        e_sv;
    logic [15:0] e_saddr;
    logic        e_pop, e_busy, e_to, e_ud;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [1:0] rv, input logic [15:0] a0, input logic [15:0] a1,
                     input logic full, input logic empty, input logic [15:0] head,
                     input logic srdy, input logic sdone,
                     input logic [1:0] e_rdy, input logic e_push, input logic [15:0] e_ain,
                     input logic e_sv, input logic [15:0] e_saddr, input logic e_pop,
                     input logic e_busy, input logic e_to, input logic e_ud);
    vec_t v;
    v.rv = rv; v.a0 = a0; v.a1 = a1; v.full = full; v.empty = empty; v.head = head;
    v.srdy = srdy; v.sdone = sdone; v.e_rdy = e_rdy; v.e_push = e_push; v.e_ain = e_ain;
    v.e_sv = e_sv; v.e_saddr = e_saddr; v.e_pop = e_pop; v.e_busy = e_busy;
    v.e_to = e_to; v.e_ud = e_ud;
    vecs.push_back(v);
  endtask

  function automatic logic [95:0] pack_act();
    return {req_ready, biq_push, biq_addr_in, snp_valid, snp_addr,
            biq_pop, ctl_busy, err_timeout, err_unexp_done};
  endfunction

  task automatic check(input string name, input logic [95:0] exp);
    logic [95:0] act;
    act = pack_act();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid    = v.rv;
    req_addr     = {AW'(v.a1), AW'(v.a0)};
    biq_full     = v.full;
    biq_empty    = v.empty;
    biq_addr_out = AW'(v.head);
    snp_ready    = v.srdy;
    snp_done     = v.sdone;
  endtask

  initial begin
    vec_t idle_v;
    logic [95:0] exp;

    rst = 1'b1;
    idle_v = '{rv: 2'b00, a0: 16'h0, a1: 16'h0, full: 1'b0, empty: 1'b1, head: 16'h0,
               srdy: 1'b0, sdone: 1'b0, e_rdy: 2'b00, e_push: 1'b0, e_ain: 16'h0,
               e_sv: 1'b0, e_saddr: 16'h0, e_pop: 1'b0, e_busy: 1'b0, e_to: 1'b0, e_ud: 1'b0};
    drive(idle_v);

    //  rv     a0       a1      fl em head     sr sd   rdy  pu ain      sv saddr    po bu to ud
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h0,   0, 0, 0, 0);
    // round robin, starting at requester 0
    add(2'b11, 16'hA0,  16'hB0, 0, 1, 16'h0,   0, 0,   2'b01, 1, 16'hA0, 0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 0, 1, 16'h0,   0, 0,   2'b10, 1, 16'hB0, 0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 0, 1, 16'h0,   0, 0,   2'b01, 1, 16'hA0, 0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 0, 1, 16'h0,   0, 0,   2'b10, 1, 16'hB0, 0, 16'h0,   0, 0, 0, 0);
    // full backpressure, then one slot frees
    add(2'b11, 16'hA0,  16'hB0, 1, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 1, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 0, 1, 16'h0,   0, 0,   2'b01, 1, 16'hA0, 0, 16'h0,   0, 0, 0, 0);
    add(2'b11, 16'hA0,  16'hB0, 1, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h0,   0, 0, 0, 0);
    // single push (pointer at 1 wraps to 0), then drain 0x1000
    add(2'b01, 16'h1000,16'h0,  0, 1, 16'h0,   0, 0,   2'b01, 1, 16'h1000,0, 16'h0,  0, 0, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h1000,0, 0,   2'b00, 0, 16'h0,  0, 16'h0,   0, 0, 0, 0);
    add(2'b10, 16'h0,   16'h77, 0, 0, 16'h1000,1, 0,   2'b10, 1, 16'h77, 1, 16'h1000,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h1000,0, 1,   2'b00, 0, 16'h0,  0, 16'h1000,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h1000,1, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h1000,0, 0, 0, 0);
    // snoop backpressure: snp_ready low for 5 cycles, head changes underneath
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h2222,0, 0,   2'b00, 0, 16'h0,  0, 16'h1000,0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(2'b00, 16'h0, 16'h0,  0, 0, 16'h3333,0, 0,   2'b00, 0, 16'h0,  1, 16'h2222,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h3333,1, 0,   2'b00, 0, 16'h0,  1, 16'h2222,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h3333,0, 0,   2'b00, 0, 16'h0,  0, 16'h2222,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h3333,0, 0,   2'b00, 0, 16'h0,  0, 16'h2222,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h3333,0, 1,   2'b00, 0, 16'h0,  0, 16'h2222,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h2222,1, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h2222,0, 0, 0, 0);
    // done coincides with the 8th WAIT cycle: done wins, no timeout
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h4444,0, 0,   2'b00, 0, 16'h0,  0, 16'h2222,0, 0, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h4444,1, 0,   2'b00, 0, 16'h0,  1, 16'h4444,0, 1, 0, 0);
    for (int k = 0; k < 7; k++)
      add(2'b00, 16'h0, 16'h0,  0, 0, 16'h4444,0, 0,   2'b00, 0, 16'h0,  0, 16'h4444,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h4444,0, 1,   2'b00, 0, 16'h0,  0, 16'h4444,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h5555,0, 0,   2'b00, 0, 16'h0,  0, 16'h4444,1, 1, 0, 0);
    // full timeout: 8 WAIT cycles without done
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h5555,0, 0,   2'b00, 0, 16'h0,  0, 16'h4444,0, 0, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h5555,1, 0,   2'b00, 0, 16'h0,  1, 16'h5555,0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      add(2'b00, 16'h0, 16'h0,  0, 0, 16'h5555,0, 0,   2'b00, 0, 16'h0,  0, 16'h5555,0, 1, 0, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h6666,0, 0,   2'b00, 0, 16'h0,  0, 16'h5555,1, 1, 1, 0);
    // next entry issues after the dropped one
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h6666,0, 0,   2'b00, 0, 16'h0,  0, 16'h5555,0, 0, 1, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h6666,1, 0,   2'b00, 0, 16'h0,  1, 16'h6666,0, 1, 1, 0);
    add(2'b00, 16'h0,   16'h0,  0, 0, 16'h6666,0, 1,   2'b00, 0, 16'h0,  0, 16'h6666,0, 1, 1, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h6666,1, 1, 1, 0);
    // spurious done in IDLE
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 1,   2'b00, 0, 16'h0,  0, 16'h6666,0, 0, 1, 0);
    add(2'b00, 16'h0,   16'h0,  0, 1, 16'h0,   0, 0,   2'b00, 0, 16'h0,  0, 16'h6666,0, 0, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      exp = {vecs[i].e_rdy, vecs[i].e_push, AW'(vecs[i].e_ain), vecs[i].e_sv,
             AW'(vecs[i].e_saddr), vecs[i].e_pop, vecs[i].e_busy, vecs[i].e_to, vecs[i].e_ud};
      check($sformatf("vec%0d", i), exp);
    end

    // reset asserted mid-WAIT, between clock edges
    @(negedge clk);
    drive(idle_v);
    biq_empty = 1'b0;
    biq_addr_out = AW'(16'h7777);
    @(negedge clk);
    snp_ready = 1'b1;
    #1;
    check("issue_before_rst", {2'b00, 1'b0, AW'(0), 1'b1, AW'(16'h7777), 1'b0, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    snp_ready = 1'b0;
    #1;
    check("wait_before_rst", {2'b00, 1'b0, AW'(0), 1'b0, AW'(16'h7777), 1'b0, 1'b1, 1'b1, 1'b1});
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", 96'h0);
    @(negedge clk);
    biq_empty = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_after_rst", 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
